// File: rtl/elevator_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_scan_ctrl : single-car SCAN elevator scheduler with a       |
// |                      latched call bitmask and timed door.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  hold_door,
  output logic [FLOOR_W-1:0]    elevator_floor,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  door_open,
  output logic                  arrived,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCNT_W-1:0]  TCNT_LAST   = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0]  DCNT_LAST   = DCNT_W'(DOOR_CYCLES - 1);
  localparam logic [TCNT_W-1:0]  TCNT_ONE    = TCNT_W'(1);
  localparam logic [DCNT_W-1:0]  DCNT_ONE    = DCNT_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic                  dir_pref, dir_pref_nx;
  logic [TCNT_W-1:0]     tcnt, tcnt_nx;
  logic [DCNT_W-1:0]     dcnt, dcnt_nx;
  logic [FLOOR_W-1:0]    floor_nx, step_floor;
  logic [NUM_FLOORS-1:0] pending_nx, set_mask, clr_mask;
  logic [NUM_FLOORS-1:0] req_hot, step_hot, above, below;
  logic                  req_in_range, req_here, arrived_nx, req_err_nx;

  assign req_in_range = ({1'b0, req_floor} < FLOOR_LIMIT);
  assign req_here     = req_valid && req_in_range && (req_floor == elevator_floor);
  // Movement only happens with a pending bit beyond the car, so this never wraps.
  assign step_floor   = (state == MOVE_DOWN) ? (elevator_floor - FLOOR_ONE)
                                             : (elevator_floor + FLOOR_ONE);

  always_comb begin
    req_hot  = '0;
    step_hot = '0;
    above    = '0;
    below    = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      req_hot[f]  = (req_floor == FLOOR_W'(f));
      step_hot[f] = (step_floor == FLOOR_W'(f));
      above[f]    = pending[f] && (FLOOR_W'(f) > elevator_floor);
      below[f]    = pending[f] && (FLOOR_W'(f) < elevator_floor);
    end
  end

  always_comb begin
    state_nx    = state;
    floor_nx    = elevator_floor;
    dir_pref_nx = dir_pref;
    tcnt_nx     = tcnt;
    dcnt_nx     = dcnt;
    arrived_nx  = 1'b0;
    clr_mask    = '0;
    req_err_nx  = req_valid && !req_in_range;
    set_mask    = (req_valid && req_in_range) ? req_hot : '0;
    // A call for the floor the car is standing at is served by the door, not queued.
    if (req_here && (state == IDLE || state == DOOR_OPEN)) begin
      set_mask = '0;
    end

    case (state)
      IDLE: begin
        if (req_here) begin
          state_nx   = DOOR_OPEN;
          dcnt_nx    = '0;
          arrived_nx = 1'b1;
        end else if ((|above) && (dir_pref || !(|below))) begin
          state_nx    = MOVE_UP;
          dir_pref_nx = 1'b1;
          tcnt_nx     = '0;
        end else if (|below) begin
          state_nx    = MOVE_DOWN;
          dir_pref_nx = 1'b0;
          tcnt_nx     = '0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (tcnt == TCNT_LAST) begin
          floor_nx = step_floor;
          tcnt_nx  = '0;
          // Includes a call for the arrival floor landing on this same edge.
          if (|(step_hot & (pending | set_mask))) begin
            clr_mask   = step_hot;
            state_nx   = DOOR_OPEN;
            dcnt_nx    = '0;
            arrived_nx = 1'b1;
          end
        end else begin
          tcnt_nx = tcnt + TCNT_ONE;
        end
      end

      DOOR_OPEN: begin
        if (req_here || hold_door) begin
          dcnt_nx = '0;
        end else if (dcnt != DCNT_LAST) begin
          dcnt_nx = dcnt + DCNT_ONE;
        end else if (dir_pref ? (|above) : (|below)) begin
          state_nx = dir_pref ? MOVE_UP : MOVE_DOWN;
          tcnt_nx  = '0;
        end else if (dir_pref ? (|below) : (|above)) begin
          state_nx    = dir_pref ? MOVE_DOWN : MOVE_UP;
          dir_pref_nx = !dir_pref;
          tcnt_nx     = '0;
        end else begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase

    pending_nx = (pending | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      elevator_floor <= '0;
      pending        <= '0;
      dir_pref       <= 1'b1;
      tcnt           <= '0;
      dcnt           <= '0;
      dir_up         <= 1'b0;
      dir_down       <= 1'b0;
      door_open      <= 1'b0;
      arrived        <= 1'b0;
      req_err        <= 1'b0;
    end else begin
      state          <= state_nx;
      elevator_floor <= floor_nx;
      pending        <= pending_nx;
      dir_pref       <= dir_pref_nx;
      tcnt           <= tcnt_nx;
      dcnt           <= dcnt_nx;
      dir_up         <= (state_nx == MOVE_UP);
      dir_down       <= (state_nx == MOVE_DOWN);
      door_open      <= (state_nx == DOOR_OPEN);
      arrived        <= arrived_nx;
      req_err        <= req_err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_elevator_scan_ctrl : directed bench with an arrival-order         |
// |                         scoreboard for elevator_scan_ctrl.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_elevator_scan_ctrl;

  localparam int NF = 16;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          hold_door = 1'b0;
  logic [FW-1:0] elevator_floor;
  logic          dir_up, dir_down, door_open, arrived, req_err;
  logic [NF-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int door_len;

  elevator_scan_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(8), .DOOR_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .hold_door(hold_door), .elevator_floor(elevator_floor), .dir_up(dir_up),
    .dir_down(dir_down), .door_open(door_open), .arrived(arrived),
    .req_err(req_err), .pending(pending)
  );

  always #5 clk = ~clk;

  logic settled;
  assign settled = !dir_up && !dir_down && !door_open && (pending == '0);

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_settled(input string tag);
    int i = 0;
    while (!settled && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, int'(settled), 1);
  endtask

  task automatic wait_floor_up(input string tag, input logic [FW-1:0] f);
    int i = 0;
    while (!(dir_up && elevator_floor == f) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, int'(dir_up && elevator_floor == f), 1);
  endtask

  task automatic wait_down(input string tag);
    int i = 0;
    while (!dir_down && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, int'(dir_down), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // Scoreboard: each door-opening arrival must match the next queued floor.
  always @(negedge clk) begin
    if (reset && arrived) begin
      chk("arrival_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("arrival_floor", int'(elevator_floor), exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_floor", int'(elevator_floor), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_outputs", int'({dir_up, dir_down, door_open, arrived, req_err}), 0);
    reset = 1'b1;
    tick(2);

    // Single call to floor 3: cycle-exact travel and door timing
    req_valid = 1'b1; req_floor = 5'd3; exp_q.push_back(3);
    tick(1);                                    // after E0
    req_valid = 1'b0;
    chk("t1_pending_e0", int'(pending), 32'h0008);
    chk("t1_idle_e0", int'(dir_up), 0);
    tick(1);                                    // E1
    chk("t1_move_e1", int'(dir_up), 1);
    tick(7);                                    // E8
    chk("t1_floor_e8", int'(elevator_floor), 0);
    tick(1);                                    // E9
    chk("t1_floor_e9", int'(elevator_floor), 1);
    tick(8);                                    // E17
    chk("t1_floor_e17", int'(elevator_floor), 2);
    tick(7);                                    // E24
    chk("t1_door_e24", int'(door_open), 0);
    tick(1);                                    // E25
    chk("t1_floor_e25", int'(elevator_floor), 3);
    chk("t1_arr_door_e25", int'({arrived, door_open, dir_up}), 3'b110);
    chk("t1_pending_e25", int'(pending), 0);
    tick(1);
    chk("t1_arr_pulse_e26", int'(arrived), 0);
    tick(8);                                    // E34
    chk("t1_door_e34", int'(door_open), 1);
    tick(1);                                    // E35
    chk("t1_idle_e35", int'(settled), 1);

    // From floor 0: calls 5 then 2 -> served 2 then 5
    pulse_reset();
    req_valid = 1'b1; req_floor = 5'd5; exp_q.push_back(2); exp_q.push_back(5);
    tick(1);
    req_floor = 5'd2;
    tick(1);
    req_valid = 1'b0;
    chk("t2_pending", int'(pending), 32'h0024);
    chk("t2_moving", int'(dir_up), 1);
    wait_settled("t2_settle");
    chk("t2_floor", int'(elevator_floor), 5);

    // Passed-floor call served on the reverse sweep
    pulse_reset();
    req_valid = 1'b1; req_floor = 5'd9; exp_q.push_back(9); exp_q.push_back(2);
    tick(1);
    req_valid = 1'b0;
    wait_floor_up("t3_reach5", 5'd5);
    req_valid = 1'b1; req_floor = 5'd2;
    tick(1);
    req_valid = 1'b0;
    chk("t3_pending", int'(pending), 32'h0204);
    wait_down("t3_flip");
    chk("t3_flip_floor", int'(elevator_floor), 9);
    wait_settled("t3_settle");
    chk("t3_floor", int'(elevator_floor), 2);

    // Same-floor call while idle, door held for five cycles
    req_valid = 1'b1; req_floor = 5'd6; exp_q.push_back(6);
    tick(1);
    req_valid = 1'b0;
    wait_settled("t4_reach6");
    chk("t4_floor6", int'(elevator_floor), 6);
    req_valid = 1'b1; req_floor = 5'd6; exp_q.push_back(6);
    tick(1);                                    // after E0
    req_valid = 1'b0;
    chk("t4_arr_door", int'({arrived, door_open}), 2'b11);
    chk("t4_not_queued", int'(pending), 0);
    door_len = 0;
    for (int i = 0; i < 100; i++) begin
      if (!door_open) break;
      door_len++;
      hold_door = (i < 5);
      @(negedge clk);
    end
    hold_door = 1'b0;
    chk("t4_door_len", door_len, 15);

    // Out-of-range call
    req_valid = 1'b1; req_floor = 5'd16;
    tick(1);
    req_valid = 1'b0;
    chk("t5_req_err", int'(req_err), 1);
    chk("t5_pending", int'(pending), 0);
    chk("t5_idle", int'({dir_up, dir_down, door_open}), 0);
    tick(1);
    chk("t5_err_pulse", int'(req_err), 0);
    chk("t5_still_idle", int'(settled), 1);

    // Asynchronous reset in the middle of a move
    req_valid = 1'b1; req_floor = 5'd12; exp_q.push_back(12);
    tick(1);
    req_valid = 1'b0;
    wait_floor_up("t6_reach7", 5'd7);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_floor", int'(elevator_floor), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_outputs", int'({dir_up, dir_down, door_open, arrived}), 0);
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("t6_stays_idle", int'(settled && elevator_floor == 0), 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
